// File: rtl/multi_booth_r4.sv
// Radix-4 Booth sequential multiplier with per-operation signed/unsigned mode.
// Handshake: rising edge of start launches; valid pulses with the registered product.
module multi_booth_r4 #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   mlier,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] prodt,
  output logic               valid,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int MW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH / 2 + 2);
  localparam logic [CW-1:0] K_SIGNED   = CW'(WIDTH / 2);
  localparam logic [CW-1:0] K_UNSIGNED = CW'(WIDTH / 2 + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic            start_q;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mc;
  logic [PW-1:0]   addend;
  logic [MW-1:0]   mr;
  logic            ovl;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   k_lim;
  logic            launch;
  logic            zero_tail;
  logic            finish;

  // Remaining digits are all zero once mr is pure sign extension matching ovl.
  always_comb begin
    launch    = (state == S_IDLE) && start && !start_q;
    zero_tail = ((mr == '0) && !ovl) || ((&mr) && ovl);
    finish    = (state == S_ITER) && ((cnt == k_lim) || (EARLY_TERM && zero_tail));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_ITER;
      S_ITER:  if (finish) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Booth digit from {mr[1], mr[0], ovl}: 0, +-mc, +-2mc.
  always_comb begin
    addend = '0;
    case ({mr[1:0], ovl})
      3'b001, 3'b010: addend = mc;
      3'b011:         addend = {mc[PW-2:0], 1'b0};
      3'b100:         addend = -{mc[PW-2:0], 1'b0};
      3'b101, 3'b110: addend = -mc;
      default:        addend = '0;
    endcase
  end

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      start_q <= 1'b0;
      prodt   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      start_q <= start;
      valid   <= finish;
      if (launch) begin
        busy <= 1'b1;
        acc  <= '0;
        cnt  <= '0;
      end else if (finish) begin
        prodt <= acc;
      end else if (state == S_ITER) begin
        acc <= acc + addend;
        cnt <= cnt + CW'(1);
      end
      if (state == S_DONE) busy <= 1'b0;
    end
  end

  // NOTE: operand shift registers carry no reset; they are always loaded at
  // launch before being read, so a reset would only add routing.
  always_ff @(posedge clock) begin
    if (launch) begin
      ovl   <= 1'b0;
      k_lim <= signed_mode ? K_SIGNED : K_UNSIGNED;
      mr    <= signed_mode ? {{2{mlier[WIDTH-1]}}, mlier} : {2'b00, mlier};
      mc    <= signed_mode ? {{WIDTH{mcand[WIDTH-1]}}, mcand} : {{WIDTH{1'b0}}, mcand};
    end else if ((state == S_ITER) && !finish) begin
      ovl <= mr[1];
      mr  <= {{2{mr[MW-1]}}, mr[MW-1:2]};
      mc  <= {mc[PW-3:0], 2'b00};
    end
  end

endmodule
